// File: rtl/pipe_reg_skid.sv
// Two-entry pipeline register with skid buffer, flush and 1-cycle latency.
// Optional stall/flush performance counters are enabled by PIPE_REG_SKID_PERF_EN.
module pipe_reg_skid #(
    parameter int                DATA_W     = 96,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    // State encoding equals the occupancy count, so occ is the state register itself.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    logic w_out_valid;
    logic w_accept;
    logic w_deliver;

    // NOTE: in_ready depends on registered state only; the skid entry absorbs the
    // beat that arrives in the cycle downstream stalls, so no out_ready path is needed.
    assign in_ready    = (r_state != S_FULL);
    assign w_out_valid = (r_state != S_EMPTY) && !flush;
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_deliver   = w_out_valid && out_ready;

    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? r_main : BUBBLE_VAL;
    assign occ       = r_state;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else if (flush) begin
            r_state <= S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) r_state <= S_ONE;
                end
                S_ONE: begin
                    if (w_accept && !w_deliver)      r_state <= S_FULL;
                    else if (!w_accept && w_deliver) r_state <= S_EMPTY;
                end
                S_FULL: begin
                    if (w_deliver) r_state <= S_ONE;
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    // NOTE: payload registers carry no reset; their contents are only observed
    // while r_state marks them valid, which saves reset fan-out on wide data.
    always_ff @(posedge clk) begin
        case (r_state)
            S_EMPTY: begin
                if (w_accept) r_main <= in_data;
            end
            S_ONE: begin
                if (w_accept && w_deliver) r_main <= in_data;
                else if (w_accept)         r_skid <= in_data;
            end
            S_FULL: begin
                if (w_deliver) r_main <= r_skid;
            end
            default: ;
        endcase
    end

`ifdef PIPE_REG_SKID_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating event counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_reg_skid.md
PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, giving the payload width (instruction, PC and PC+4 packed).
REQ-002 The block SHALL have parameter BUBBLE_VAL, default 0, giving the DATA_W-bit value driven on out_data when no valid beat is presented.
REQ-003 The block SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port flush  input  1  discard all held and incoming beats.
REQ-006 The block SHALL have port in_valid  input  1  upstream beat present.
REQ-007 The block SHALL have port in_ready  output  1  block can accept a beat this cycle.
REQ-008 The block SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 The block SHALL have port out_valid  output  1  downstream beat present.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts (stall = !out_ready).
REQ-011 The block SHALL have port out_data  output  DATA_W  downstream payload.
REQ-012 The block SHALL have port occ  output  2  entries held (0, 1 or 2).
REQ-013 The block SHALL have port stall_cnt  output  32  cycles with out_valid && !out_ready.
REQ-014 The block SHALL have port flush_cnt  output  32  cycles with flush asserted.

Function
REQ-015 The block SHALL hold a main entry and a skid entry, giving states EMPTY (occ=0), ONE (occ=1, main valid) and FULL (occ=2, main and skid valid).
REQ-016 Accept SHALL be in_valid && in_ready && !flush; deliver SHALL be out_valid && out_ready.
REQ-017 in_ready SHALL equal (state != FULL) and be driven from registered state only, with no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 in ONE or FULL and 0 otherwise, and SHALL be forced to 0 in any cycle where flush=1.
REQ-019 out_data SHALL be the main entry when out_valid=1 and BUBBLE_VAL otherwise, including during flush.
REQ-020 Latency SHALL be 1 cycle: a beat accepted in cycle N SHALL appear on out_data in cycle N+1 if the block was EMPTY, or ONE with deliver.
REQ-021 Transitions from EMPTY: accept -> ONE with main<=in_data; otherwise stay in EMPTY.
REQ-022 Transitions from ONE: accept&deliver -> ONE with main<=in_data; accept&!deliver -> FULL with skid<=in_data; !accept&deliver -> EMPTY; otherwise hold.
REQ-023 Transitions from FULL: deliver -> ONE with main<=skid; otherwise hold, with both entries unchanged.
REQ-024 flush SHALL take priority over accept and deliver, leaving the block in EMPTY next cycle, with the in_data of that cycle discarded and no deliver counted.
REQ-025 Beats SHALL leave in acceptance order, with no duplication and no loss except by flush.
REQ-026 With out_ready held at 1, the block SHALL sustain one beat per cycle indefinitely.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL enter EMPTY with occ=0, out_valid=0, out_data=BUBBLE_VAL, in_ready=1, and both counters at 0.
REQ-028 rst SHALL take priority over flush and over any handshake, and beats held when reset is asserted mid-operation SHALL be discarded.

Configuration
REQ-029 When PIPE_REG_SKID_PERF_EN is defined, stall_cnt and flush_cnt SHALL each count their event per cycle and saturate at 32'hFFFFFFFF without wrapping.
REQ-030 When PIPE_REG_SKID_PERF_EN is undefined, no counter logic SHALL exist, stall_cnt and flush_cnt SHALL be tied to 0, and the port list SHALL be unchanged.

Verification
REQ-031 Reset then stream: in_valid=1 with data 1..8 and out_ready=1 -> out_data 1..8 on consecutive cycles, one cycle behind, with occ=1 throughout.
REQ-032 Back-pressure: send A, B, C with out_ready=0 -> occ goes 1, 2; in_ready=0 at FULL; C is held upstream; after out_ready=1, output is A, B, C in order.
REQ-033 Flush while FULL with in_valid=1 and data D -> out_valid=0 and out_data=BUBBLE_VAL in the flush cycle; next cycle occ=0; D is never output.
REQ-034 Simultaneous accept and deliver in ONE, holding X with input Y -> next cycle out_data=Y and occ=1.
REQ-035 rst asserted while FULL -> next cycle occ=0, out_valid=0 and in_ready=1; with PIPE_REG_SKID_PERF_EN defined, 5 stalled cycles give stall_cnt=5 and flush_cnt=0 until rst clears both.
